memory_access: RTL and testbench

Memory stage of the 5-stage MIPS pipeline, directly downstream of the execute stage. It owns the word-addressed data memory and consumes the execute-stage results: ALU result/address, store data, destination register and control bits. It performs loads and stores and registers the results into the MEM/WB pipeline register for writeback. After every reset it zero-clears the data memory with a sequencer and reports busy while doing so. It detects and suppresses faulting accesses.

---
 rtl/memory_access.sv | 159 +++++++++++++++
 tb/tb_memory_access.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// MEM stage of the 5-stage MIPS pipeline: word-addressed data memory, MEM/WB register,
// post-reset zero-clear sequencer and faulting-access suppression.
module memory_access #(
  parameter int unsigned DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  XM_RD,
  input  logic [31:0] XM_B,
  input  logic [31:0] ALUout,
  input  logic        XM_MemWrite,
  input  logic        XM_MemToReg,
  input  logic        XM_RegWrite,
  output logic [4:0]  MW_RD,
  output logic [31:0] MW_ALUout,
  output logic [31:0] MW_MemData,
  output logic        MW_MemToReg,
  output logic        MW_RegWrite,
  output logic        MemBusy,
  output logic        MemFault,
  output logic [7:0]  FaultCnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [AW-1:0] clr_idx_r, clr_idx_nxt_s;
  logic          busy_r, busy_nxt_s;
  logic [31:0]   mem_r [DEPTH];

  logic [4:0]    mw_rd_r, mw_rd_nxt_s;
  logic [31:0]   mw_alu_r, mw_alu_nxt_s;
  logic [31:0]   mw_data_r, mw_data_nxt_s;
  logic          mw_m2r_r, mw_m2r_nxt_s;
  logic          mw_rw_r, mw_rw_nxt_s;
  logic          fault_r, fault_nxt_s;
  logic [7:0]    fault_cnt_r, fault_cnt_nxt_s;

  logic          mem_we_s;
  logic [AW-1:0] mem_addr_s;
  logic [31:0]   mem_wdata_s;
  logic [AW-1:0] word_idx_s;
  logic          fault_s;

  // Misaligned word address, or any address bit above the memory's byte range set.
  function automatic logic access_fault(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr[31:AW+2] != {(30-AW){1'b0}});
  endfunction

  assign word_idx_s = ALUout[AW+1:2];
  assign fault_s    = (XM_MemWrite | XM_MemToReg) & access_fault(ALUout);

  // Next-state, memory write port and MEM/WB register inputs.
  always_comb begin
    state_nxt_s     = state_r;
    clr_idx_nxt_s   = clr_idx_r;
    busy_nxt_s      = busy_r;
    mem_we_s        = 1'b0;
    mem_addr_s      = clr_idx_r;
    mem_wdata_s     = 32'd0;
    mw_rd_nxt_s     = 5'd0;
    mw_alu_nxt_s    = 32'd0;
    mw_data_nxt_s   = 32'd0;
    mw_m2r_nxt_s    = 1'b0;
    mw_rw_nxt_s     = 1'b0;
    fault_nxt_s     = 1'b0;
    fault_cnt_nxt_s = fault_cnt_r;
    case (state_r)
      CLEAR: begin
        mem_we_s      = 1'b1;
        mem_addr_s    = clr_idx_r;
        mem_wdata_s   = 32'd0;
        clr_idx_nxt_s = clr_idx_r + AW'(1);
        if (clr_idx_r == AW'(DEPTH - 1)) begin
          state_nxt_s = RUN;
          busy_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = CLEAR;
          busy_nxt_s  = 1'b1;
        end
      end
      RUN: begin
        mem_we_s     = XM_MemWrite & ~fault_s;
        mem_addr_s   = word_idx_s;
        mem_wdata_s  = XM_B;
        mw_rd_nxt_s  = XM_RD;
        mw_alu_nxt_s = ALUout;
        mw_m2r_nxt_s = XM_MemToReg;
        // A store wins over a simultaneous load, so only a pure, clean load returns data.
        if (XM_MemToReg && !XM_MemWrite && !fault_s) begin
          mw_data_nxt_s = mem_r[word_idx_s];
        end else begin
          mw_data_nxt_s = 32'd0;
        end
        mw_rw_nxt_s = XM_RegWrite & ~(XM_MemToReg & fault_s);
        fault_nxt_s = fault_s;
        if (fault_s && (fault_cnt_r != 8'd255)) begin
          fault_cnt_nxt_s = fault_cnt_r + 8'd1;
        end else begin
          fault_cnt_nxt_s = fault_cnt_r;
        end
      end
      default: begin
        state_nxt_s   = CLEAR;
        clr_idx_nxt_s = {AW{1'b0}};
        busy_nxt_s    = 1'b1;
      end
    endcase
  end

  // Control state and MEM/WB pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= CLEAR;
      clr_idx_r   <= {AW{1'b0}};
      busy_r      <= 1'b1;
      mw_rd_r     <= 5'd0;
      mw_alu_r    <= 32'd0;
      mw_data_r   <= 32'd0;
      mw_m2r_r    <= 1'b0;
      mw_rw_r     <= 1'b0;
      fault_r     <= 1'b0;
      fault_cnt_r <= 8'd0;
    end else begin
      state_r     <= state_nxt_s;
      clr_idx_r   <= clr_idx_nxt_s;
      busy_r      <= busy_nxt_s;
      mw_rd_r     <= mw_rd_nxt_s;
      mw_alu_r    <= mw_alu_nxt_s;
      mw_data_r   <= mw_data_nxt_s;
      mw_m2r_r    <= mw_m2r_nxt_s;
      mw_rw_r     <= mw_rw_nxt_s;
      fault_r     <= fault_nxt_s;
      fault_cnt_r <= fault_cnt_nxt_s;
    end
  end

  // Data memory write port; nothing is written on a reset edge.
  always_ff @(posedge clk) begin
    if (!rst && mem_we_s) begin
      mem_r[mem_addr_s] <= mem_wdata_s;
    end
  end

  assign MW_RD       = mw_rd_r;
  assign MW_ALUout   = mw_alu_r;
  assign MW_MemData  = mw_data_r;
  assign MW_MemToReg = mw_m2r_r;
  assign MW_RegWrite = mw_rw_r;
  assign MemBusy     = busy_r;
  assign MemFault    = fault_r;
  assign FaultCnt    = fault_cnt_r;

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: stimulus pushes expected MEM/WB contents,
// a negedge monitor pops and compares them one cycle after issue.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  XM_RD = 5'd0;
  logic [31:0] XM_B = 32'd0;
  logic [31:0] ALUout = 32'd0;
  logic        XM_MemWrite = 1'b0;
  logic        XM_MemToReg = 1'b0;
  logic        XM_RegWrite = 1'b0;
  logic [4:0]  MW_RD;
  logic [31:0] MW_ALUout;
  logic [31:0] MW_MemData;
  logic        MW_MemToReg;
  logic        MW_RegWrite;
  logic        MemBusy;
  logic        MemFault;
  logic [7:0]  FaultCnt;

  memory_access #(.DEPTH(32)) dut (
    .clk(clk), .rst(rst),
    .XM_RD(XM_RD), .XM_B(XM_B), .ALUout(ALUout),
    .XM_MemWrite(XM_MemWrite), .XM_MemToReg(XM_MemToReg), .XM_RegWrite(XM_RegWrite),
    .MW_RD(MW_RD), .MW_ALUout(MW_ALUout), .MW_MemData(MW_MemData),
    .MW_MemToReg(MW_MemToReg), .MW_RegWrite(MW_RegWrite),
    .MemBusy(MemBusy), .MemFault(MemFault), .FaultCnt(FaultCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] data;
    logic        m2r;
    logic        rw;
    logic        flt;
    logic [7:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   cycle_cnt = 0;
  int   errors = 0;
  int   checks = 0;
  int   model_cnt = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cycle_cnt) begin
      exp_t e;
      e = q.pop_front();
      chk({e.name, ".on_time"}, 32'(e.cyc), 32'(cycle_cnt));
      chk({e.name, ".MW_RD"}, {27'd0, MW_RD}, {27'd0, e.rd});
      chk({e.name, ".MW_ALUout"}, MW_ALUout, e.alu);
      chk({e.name, ".MW_MemData"}, MW_MemData, e.data);
      chk({e.name, ".MW_MemToReg"}, {31'd0, MW_MemToReg}, {31'd0, e.m2r});
      chk({e.name, ".MW_RegWrite"}, {31'd0, MW_RegWrite}, {31'd0, e.rw});
      chk({e.name, ".MemFault"}, {31'd0, MemFault}, {31'd0, e.flt});
      chk({e.name, ".FaultCnt"}, {24'd0, FaultCnt}, {24'd0, e.cnt});
      chk({e.name, ".MemBusy"}, {31'd0, MemBusy}, 32'd0);
    end
  end

  // Drive one instruction, record its hand-computed MEM/WB image, advance one cycle.
  task automatic issue(input string nm, input logic wr, input logic ld, input logic rw,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] b,
                       input logic [31:0] exp_data, input logic exp_rw, input logic exp_flt);
    exp_t e;
    XM_MemWrite = wr; XM_MemToReg = ld; XM_RegWrite = rw;
    XM_RD = rd; ALUout = alu; XM_B = b;
    if (exp_flt && model_cnt < 255) model_cnt++;
    e.cyc = cycle_cnt + 1; e.name = nm; e.rd = rd; e.alu = alu; e.data = exp_data;
    e.m2r = ld; e.rw = exp_rw; e.flt = exp_flt; e.cnt = 8'(model_cnt);
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    XM_MemWrite = 1'b0; XM_MemToReg = 1'b0; XM_RegWrite = 1'b0;
    XM_RD = 5'd0; ALUout = 32'd0; XM_B = 32'd0;
  endtask

  // Count busy cycles after release; also OR together every MW_* bit seen meanwhile.
  task automatic wait_clear(input string nm);
    int          busy_cycles;
    logic [31:0] seen;
    busy_cycles = 0;
    seen = 32'd0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      seen = seen | MW_ALUout | MW_MemData | {27'd0, MW_RD} |
             {29'd0, MW_MemToReg, MW_RegWrite, MemFault};
      if (MemBusy) busy_cycles++;
      else break;
    end
    chk({nm, ".busy_cycles"}, 32'(busy_cycles), 32'd32);
    chk({nm, ".outputs_during_clear"}, seen, 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.MemBusy", {31'd0, MemBusy}, 32'd1);
    chk("reset.outputs", MW_ALUout | MW_MemData | {27'd0, MW_RD} |
        {29'd0, MW_MemToReg, MW_RegWrite, MemFault}, 32'd0);
    chk("reset.FaultCnt", {24'd0, FaultCnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_cnt = 0;
    wait_clear("clear1");

    for (int a = 0; a < 32; a++)
      issue("lw_zero", 1'b0, 1'b1, 1'b1, 5'd1, 32'(a * 4), 32'd0, 32'd0, 1'b1, 1'b0);

    issue("sw_beef", 1'b1, 1'b0, 1'b0, 5'd0, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0);
    issue("lw_beef", 1'b0, 1'b1, 1'b1, 5'd5, 32'h10, 32'd0, 32'hDEADBEEF, 1'b1, 1'b0);
    issue("alu_pass", 1'b0, 1'b0, 1'b1, 5'd9, 32'h12345678, 32'd0, 32'd0, 1'b1, 1'b0);

    issue("sw_misal", 1'b1, 1'b0, 1'b0, 5'd0, 32'h12, 32'h11111111, 32'd0, 1'b0, 1'b1);
    issue("after_misal", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    issue("lw_unchanged", 1'b0, 1'b1, 1'b1, 5'd6, 32'h10, 32'd0, 32'hDEADBEEF, 1'b1, 1'b0);
    issue("lw_oor", 1'b0, 1'b1, 1'b1, 5'd3, 32'h80, 32'd0, 32'd0, 1'b0, 1'b1);
    issue("after_oor", 1'b0, 1'b0, 1'b1, 5'd4, 32'h44, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fault_count_two", {24'd0, FaultCnt}, 32'd2);

    issue("sw_and_lw", 1'b1, 1'b1, 1'b1, 5'd2, 32'h20, 32'h0BADF00D, 32'd0, 1'b1, 1'b0);
    issue("lw_after_both", 1'b0, 1'b1, 1'b1, 5'd2, 32'h20, 32'd0, 32'h0BADF00D, 1'b1, 1'b0);
    issue("sw_top", 1'b1, 1'b0, 1'b0, 5'd0, 32'h7C, 32'hCAFEF00D, 32'd0, 1'b0, 1'b0);
    issue("lw_top", 1'b0, 1'b1, 1'b1, 5'd8, 32'h7C, 32'd0, 32'hCAFEF00D, 1'b1, 1'b0);

    for (int i = 0; i < 300; i++)
      issue("lw_sat", 1'b0, 1'b1, 1'b1, 5'd7, 32'h81, 32'd0, 32'd0, 1'b0, 1'b1);
    idle_inputs();
    @(negedge clk);
    chk("fault_count_sat", {24'd0, FaultCnt}, 32'd255);

    issue("sw_a5", 1'b1, 1'b0, 1'b0, 5'd0, 32'h04, 32'hA5A5A5A5, 32'd0, 1'b0, 1'b0);
    issue("lw_a5", 1'b0, 1'b1, 1'b1, 5'd1, 32'h04, 32'd0, 32'hA5A5A5A5, 1'b1, 1'b0);
    idle_inputs();
    @(negedge clk);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    XM_MemWrite = 1'b1; XM_RegWrite = 1'b1; XM_RD = 5'd7; ALUout = 32'h04; XM_B = 32'hFFFFFFFF;
    @(posedge clk); #1;
    rst = 1'b0;
    model_cnt = 0;
    wait_clear("clear_mid");
    chk("mid.FaultCnt", {24'd0, FaultCnt}, 32'd0);

    issue("lw_cleared_04", 1'b0, 1'b1, 1'b1, 5'd1, 32'h04, 32'd0, 32'd0, 1'b1, 1'b0);
    issue("lw_cleared_10", 1'b0, 1'b1, 1'b1, 5'd1, 32'h10, 32'd0, 32'd0, 1'b1, 1'b0);
    issue("lw_cleared_7c", 1'b0, 1'b1, 1'b1, 5'd1, 32'h7C, 32'd0, 32'd0, 1'b1, 1'b0);
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
